// File: rtl/trace_ctrl.sv
// rtl/trace_ctrl.sv - trail push arbitration and chronological backtrack control
module trace_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       imp_valid,
  input  logic [8:0] imp_var,
  input  logic       imp_val,
  output logic       imp_ready,
  input  logic       dec_valid,
  input  logic [8:0] dec_var,
  input  logic       dec_val,
  output logic       dec_ready,
  input  logic       conflict,
  output logic       tt_push,
  output logic       tt_pop,
  output logic       tt_type,
  output logic       tt_val,
  output logic [8:0] tt_variable,
  input  logic       tt_type_in,
  input  logic       tt_val_in,
  input  logic [8:0] tt_variable_in,
  input  logic       tt_empty,
  input  logic       tt_full,
  output logic       unassign_valid,
  output logic [8:0] unassign_var,
  output logic       flip_valid,
  output logic [8:0] flip_var,
  output logic       flip_val,
  output logic       bt_busy,
  output logic       unsat,
  output logic [9:0] dec_level
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BT_POP  = 2'd1,
    BT_FLIP = 2'd2,
    UNSAT   = 2'd3
  } state_t;

  state_t     state;
  logic [8:0] flip_var_q;
  logic       flip_val_q;
  logic       dec_accept;

  // Strobes are gated by reset so they drop the instant reset asserts.
  always_comb begin
    imp_ready      = 1'b0;
    dec_ready      = 1'b0;
    tt_push        = 1'b0;
    tt_pop         = 1'b0;
    tt_type        = 1'b0;
    tt_val         = 1'b0;
    tt_variable    = 9'd0;
    unassign_valid = 1'b0;
    unassign_var   = 9'd0;
    flip_valid     = 1'b0;
    flip_var       = 9'd0;
    flip_val       = 1'b0;
    dec_accept     = 1'b0;
    if (reset) begin
      case (state)
        IDLE: begin
          if (!conflict && !tt_full) begin
            imp_ready = 1'b1;
            dec_ready = !imp_valid;
          end
          if (imp_valid && imp_ready) begin
            tt_push     = 1'b1;
            tt_type     = 1'b1;
            tt_val      = imp_val;
            tt_variable = imp_var;
          end else if (dec_valid && dec_ready) begin
            tt_push     = 1'b1;
            tt_type     = 1'b0;
            tt_val      = dec_val;
            tt_variable = dec_var;
            dec_accept  = 1'b1;
          end
        end
        BT_POP: begin
          if (!tt_empty) begin
            tt_pop         = 1'b1;
            unassign_valid = 1'b1;
            unassign_var   = tt_variable_in;
          end
        end
        BT_FLIP: begin
          tt_push     = 1'b1;
          tt_type     = 1'b1;
          tt_val      = flip_val_q;
          tt_variable = flip_var_q;
          flip_valid  = 1'b1;
          flip_var    = flip_var_q;
          flip_val    = flip_val_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      dec_level  <= 10'd0;
      flip_var_q <= 9'd0;
      flip_val_q <= 1'b0;
      bt_busy    <= 1'b0;
      unsat      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (conflict) begin
            state   <= BT_POP;
            bt_busy <= 1'b1;
          end else if (dec_accept) begin
            dec_level <= dec_level + 10'd1;
          end
        end
        BT_POP: begin
          if (tt_empty) begin
            state   <= UNSAT;
            bt_busy <= 1'b0;
            unsat   <= 1'b1;
          end else if (!tt_type_in) begin
            // Decision reached: its opposite value becomes a forced entry.
            flip_var_q <= tt_variable_in;
            flip_val_q <= ~tt_val_in;
            dec_level  <= dec_level - 10'd1;
            state      <= BT_FLIP;
          end
        end
        BT_FLIP: begin
          state   <= IDLE;
          bt_busy <= 1'b0;
        end
        default: begin
          state <= UNSAT;
        end
      endcase
    end
  end

endmodule

// File: doc/trace_ctrl.md
TRACE_CTRL -- requirements
Module: trace_ctrl

Interface
REQ-001 SHALL have ports (name  direction  width  meaning): clk  in  1  sole clock, rising edge; reset  in  1  asynchronous, active-low reset.
REQ-002 SHALL have imp_valid in 1, imp_var in 9, imp_val in 1: forced-assignment push request from implication unit; imp_ready out 1.
REQ-003 SHALL have dec_valid in 1, dec_var in 9, dec_val in 1: decision push request from decider; dec_ready out 1.
REQ-004 SHALL have conflict in 1: single-cycle conflict pulse from clause evaluator.
REQ-005 SHALL have to trace_table: tt_push out 1, tt_pop out 1, tt_type out 1 (D=0/F=1), tt_val out 1, tt_variable out 9.
REQ-006 SHALL have from trace_table: tt_type_in in 1, tt_val_in in 1, tt_variable_in in 9 (top-of-stack, valid whenever tt_empty=0), tt_empty in 1, tt_full in 1.
REQ-007 SHALL have unassign_valid out 1, unassign_var out 9: clears a variable in the assignment store.
REQ-008 SHALL have flip_valid out 1, flip_var out 9, flip_val out 1: writes a flipped decision to the assignment store.
REQ-009 SHALL have bt_busy out 1, unsat out 1, dec_level out 10 (current decision level).

Function
REQ-010 SHALL implement states IDLE, BT_POP, BT_FLIP, UNSAT; only IDLE accepts pushes.
REQ-011 SHALL in IDLE, with conflict=0 and tt_full=0, drive imp_ready=1; dec_ready=1 only when additionally imp_valid=0 (implications have priority).
REQ-012 SHALL assert at most one tt_push per cycle; a push occurs when valid&&ready, with tt_type=1 for imp, 0 for dec, and var/val passed combinationally.
REQ-013 SHALL increment dec_level on the clock edge of an accepted decision push.
REQ-014 SHALL on conflict=1 in IDLE deassert both readies that cycle, perform no push, and enter BT_POP next cycle.
REQ-015 SHALL in BT_POP with tt_empty=0: assert tt_pop and unassign_valid with unassign_var=tt_variable_in; if tt_type_in=1 remain BT_POP; if tt_type_in=0 register var and ~tt_val_in, decrement dec_level, go BT_FLIP.
REQ-016 SHALL in BT_POP with tt_empty=1: no pop, no unassign, enter UNSAT.
REQ-017 SHALL in BT_FLIP for one cycle: tt_push=1, tt_type=1, tt_variable/tt_val = registered var/flipped val; flip_valid=1 with same var/val; then return to IDLE.
REQ-018 SHALL hold bt_busy=1 in BT_POP and BT_FLIP, 0 otherwise; backtrack over k forced entries plus one decision takes k+1 BT_POP cycles + 1 BT_FLIP cycle.
REQ-019 SHALL ignore conflict outside IDLE.
REQ-020 SHALL in UNSAT hold unsat=1, both readies 0, no tt_push/tt_pop, until reset.
REQ-021 SHALL never assert tt_push and tt_pop in the same cycle.
REQ-022 SHALL keep tt_*, unassign_*, flip_* command outputs 0 in any cycle where their strobe is not asserted.

Reset
REQ-023 SHALL on reset=0, asynchronously enter IDLE, clear dec_level, unsat, bt_busy, registered flip data, and drive all strobes 0.
REQ-024 SHALL on reset asserted mid-backtrack abandon the backtrack with no further pop or push after release.
REQ-025 SHALL resume normal operation on the first rising clk edge after reset returns to 1.

Verification
REQ-026 SHALL cover: push dec(var 5,val 1), then imp(var 9,val 0) -> tt_push twice, tt_type 0 then 1, dec_level=1.
REQ-027 SHALL cover: imp_valid and dec_valid same cycle -> imp pushed, dec_ready=0, dec pushed next cycle.
REQ-028 SHALL cover: stack [D(5,1), F(9,0), F(12,1)] + conflict -> unassign 12, 9, 5 on consecutive cycles, then flip_valid with var 5 val 0, tt_push type 1, dec_level 1->0, IDLE.
REQ-029 SHALL cover: stack of only forced entries [F(3,1)] + conflict -> unassign 3, then unsat=1, readies 0 forever.
REQ-030 SHALL cover: conflict coincident with imp_valid in IDLE -> no push; conflict during BT_POP -> ignored.
REQ-031 SHALL cover: reset=0 during BT_POP -> all outputs 0 immediately, IDLE, dec_level=0 after release; tt_full=1 -> both readies 0.
